// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - per-channel two-flop synchronizer and tick-based debouncer with rise/fall pulses
module input_debounce #(
  parameter int unsigned       WIDTH        = 4,
  parameter int unsigned       TICK_DIV     = 100000,
  parameter int unsigned       STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0]  RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] s;
  logic [PW-1:0]    pre;
  logic [CW-1:0]    cnt [WIDTH];

  // Two-flop synchronizer; only s is used by the debounce logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RESET_VAL;
      s     <= RESET_VAL;
    end else begin
      sync1 <= din;
      s     <= sync1;
    end
  end

  // Shared prescaler; tick is registered off the last count so the first strobe lands TICK_DIV cycles after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pre == PRE_LAST);
      if (pre == PRE_LAST) begin
        pre <= '0;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  // Per-channel stability counters; any return to the current level restarts qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (s[i] == dout[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            dout[i] <= s[i];
            cnt[i]  <= '0;
            rise[i] <= s[i];
            fall[i] <= ~s[i];
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

endmodule
